aes_encrypt: RTL and testbench

Iterative AES-128 encryption core, the forward counterpart of the team's AES decryption block. It accepts a 128-bit plaintext and cipher key on a `Run` request and computes one full round per clock, expanding the round key on the fly. It presents the ciphertext with a `Ready` flag in the same byte layout the decryption side consumes, so `Ciphertext` feeds its input directly for loopback.

---
 rtl/aes_pkg.sv | 86 ++++++++
 rtl/aes_encrypt_if.sv | 21 ++
 rtl/aes_round.sv | 42 ++++
 rtl/aes_encrypt.sv | 116 +++++++++++
 tb/tb_aes_encrypt.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the encrypt and decrypt cores.
//   - aes_state_t : 128-bit block. Byte i is bits [127-8i -: 8], column c is
//                   bits [127-32c -: 32], row r of column c is byte 4c+r.
//   - aes_fsm_e   : sequencing states of the iterative cores.
//   - SBOX, RCON  : forward S-box and round constants (RCON[1..10] valid).
//   - xtime, mix_column, shift_rows, sub_word, key_step : round helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } aes_fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by the 4-bit round counter; entries outside 1..10 are
  // never used by a real round and are padded with zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are a0 (row 0, MSB) .. a3 (row 3, LSB).
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r is rotated left by r columns.
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic aes_state_t key_step(input aes_state_t k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rcon, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_encrypt_if.sv
// -----------------------------------------------------------------------------
// aes_encrypt_if
// Request/result bundle of the AES-128 encrypt core.
//   Run        : start request (master -> slave)
//   Plaintext  : 128-bit block, sampled in the accept cycle only
//   Cipherkey  : 128-bit key, sampled in the accept cycle only
//   Ciphertext : 128-bit result, valid while Ready=1 (slave -> master)
//   Ready      : result-valid flag (slave -> master)
// -----------------------------------------------------------------------------
interface aes_encrypt_if;
  import aes_pkg::*;

  logic       Run;
  aes_state_t Plaintext;
  aes_state_t Cipherkey;
  aes_state_t Ciphertext;
  logic       Ready;

  modport master (output Run, Plaintext, Cipherkey, input Ciphertext, Ready);
  modport slave  (input Run, Plaintext, Cipherkey, output Ciphertext, Ready);
endinterface

// File: rtl/aes_round.sv
// -----------------------------------------------------------------------------
// aes_round
// One combinational AES-128 encryption round with on-the-fly key expansion.
//   state_i : state entering the round
//   key_i   : previous round key
//   rcon_i  : round constant for this round
//   final_i : 1 for round 10 (MixColumns skipped)
//   state_o : state after AddRoundKey with the new round key
//   key_o   : new round key
// -----------------------------------------------------------------------------
module aes_round
  import aes_pkg::*;
(
  input  aes_state_t state_i,
  input  aes_state_t key_i,
  input  logic [7:0] rcon_i,
  input  logic       final_i,
  output aes_state_t state_o,
  output aes_state_t key_o
);

  aes_state_t sub_s;
  aes_state_t shift_s;
  aes_state_t mix_s;
  aes_state_t key_n;

  always_comb begin
    sub_s = '0;
    for (int i = 0; i < 16; i++) begin
      sub_s[8*i +: 8] = SBOX[state_i[8*i +: 8]];
    end
    shift_s = shift_rows(sub_s);
    mix_s = '0;
    for (int c = 0; c < 4; c++) begin
      mix_s[32*c +: 32] = mix_column(shift_s[32*c +: 32]);
    end
    key_n   = key_step(key_i, rcon_i);
    state_o = (final_i ? shift_s : mix_s) ^ key_n;
    key_o   = key_n;
  end

endmodule

// File: rtl/aes_encrypt.sv
// -----------------------------------------------------------------------------
// aes_encrypt
// Iterative AES-128 encryption core, one round per clock (two with
// AES_ENC_UNROLL2_EN defined). Ciphertext uses the same byte layout the
// decrypt core consumes, so it can be looped back directly.
//   Clk   : system clock, rising edge
//   Reset : synchronous, active-high; wins over everything
//   bus   : aes_encrypt_if.slave (Run, Plaintext, Cipherkey -> Ciphertext, Ready)
// Build option: AES_ENC_UNROLL2_EN - two rounds per edge, 5-cycle latency.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for Run, Ready=0
// ST_ROUND | rounds rnd_q.. in progress, Run ignored
// ST_DONE  | Ready=1, Ciphertext held; Run starts the next block
// -----------------------------------------------------------------------------
module aes_encrypt
  import aes_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  aes_encrypt_if.slave bus
);

`ifdef AES_ENC_UNROLL2_EN
  localparam logic [3:0] RND_STEP = 4'd2;
  localparam logic [3:0] RND_LAST = 4'd9;
`else
  localparam logic [3:0] RND_STEP = 4'd1;
  localparam logic [3:0] RND_LAST = 4'd10;
`endif

  aes_fsm_e   fsm_q;
  logic [3:0] rnd_q;
  aes_state_t state_q;
  aes_state_t key_q;
  aes_state_t ct_q;
  logic       ready_q;

  aes_state_t state_d;
  aes_state_t key_d;
  aes_state_t st0;
  aes_state_t k0;

  aes_round u_round0 (
    .state_i (state_q),
    .key_i   (key_q),
    .rcon_i  (RCON[rnd_q]),
    .final_i (rnd_q == 4'd10),
    .state_o (st0),
    .key_o   (k0)
  );

`ifdef AES_ENC_UNROLL2_EN
  // Second stage handles the even round of each pair (2, 4, .., 10).
  logic [3:0] rnd_b;
  aes_state_t st1;
  aes_state_t k1;

  assign rnd_b = rnd_q + 4'd1;

  aes_round u_round1 (
    .state_i (st0),
    .key_i   (k0),
    .rcon_i  (RCON[rnd_b]),
    .final_i (rnd_b == 4'd10),
    .state_o (st1),
    .key_o   (k1)
  );

  assign state_d = st1;
  assign key_d   = k1;
`else
  assign state_d = st0;
  assign key_d   = k0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          if (bus.Run) begin
            state_q <= bus.Plaintext ^ bus.Cipherkey;
            key_q   <= bus.Cipherkey;
            rnd_q   <= 4'd1;
            ready_q <= 1'b0;
            fsm_q   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q <= state_d;
          key_q   <= key_d;
          rnd_q   <= rnd_q + RND_STEP;
          if (rnd_q == RND_LAST) begin
            // Only the finished block ever reaches the output register.
            ct_q    <= state_d;
            ready_q <= 1'b1;
            fsm_q   <= ST_DONE;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Ciphertext = ct_q;
  assign bus.Ready      = ready_q;

endmodule

// File: tb/tb_aes_encrypt.sv
`timescale 1ns/1ps
module tb_aes_encrypt;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  aes_encrypt_if bus();

  aes_encrypt dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

`ifdef AES_ENC_UNROLL2_EN
  localparam int LAT   = 5;
  localparam int KSTEP = 2;
`else
  localparam int LAT   = 10;
  localparam int KSTEP = 1;
`endif
  localparam int PERIOD = LAT + 1;
  localparam int LIMIT  = 40;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int checks = 0;
  int passed = 0;

  // ---------------- reference model (byte-array AES from GF(2^8) maths) ----
  logic [7:0]   sb_m  [256];
  logic [7:0]   isb_m [256];
  logic [127:0] rk_m  [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b  = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  task automatic init_model();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb_m[a]  = s;
      isb_m[s] = 8'(a);
    end
  endtask

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    expand_key(key);
    for (int i = 0; i < 16; i++) s[i] = getb(pt, i) ^ getb(rk_m[0], i);
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[4*c+q] = t[4*((c+q)%4)+q];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ getb(rk_m[r], i);
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Stands in for the decryption block on the loopback path.
  function automatic logic [127:0] model_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    expand_key(key);
    for (int i = 0; i < 16; i++) s[i] = getb(ct, i) ^ getb(rk_m[10], i);
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+4-q)%4)+q];
      for (int i = 0; i < 16; i++) s[i] = isb_m[t[i]] ^ getb(rk_m[r], i);
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- stimulus helpers ---------------------------------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents a request for exactly one edge, then scrambles the data inputs.
  task automatic accept_block(input logic [127:0] pt, input logic [127:0] key);
    bus.Run       = 1'b1;
    bus.Plaintext = pt;
    bus.Cipherkey = key;
    tick();
    bus.Run       = 1'b0;
    bus.Plaintext = rand128();
    bus.Cipherkey = rand128();
  endtask

  // n = number of edges since the accept edge when Ready is first seen.
  task automatic wait_ready(input int start, output int n);
    n = start;
    while (bus.Ready !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    if (bus.Ready !== 1'b1) begin
      checks++;
      $display("FAIL ready_timeout: Ready=%b after %0d cycles, want 1", bus.Ready, n);
    end
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    Reset = 1'b1;
    bus.Run = 1'b1;
    bus.Plaintext = rand128();
    bus.Cipherkey = rand128();
    tick();
    tick();
    checks++;
    if (bus.Ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.Ready);
    else passed++;
    checks++;
    if (bus.Ciphertext !== 128'h0) $display("FAIL reset_ct: got %h want 0", bus.Ciphertext);
    else passed++;
    checks++;
    if (dut.key_q !== 128'h0) $display("FAIL reset_key: got %h want 0", dut.key_q);
    else passed++;
    Reset = 1'b0;
    bus.Run = 1'b0;
    tick();
  endtask

  task automatic test_fips_c1();
    int n;
    accept_block(C1_PT, C1_KEY);
    wait_ready(0, n);
    checks++;
    if (n !== LAT) $display("FAIL c1_latency: got %0d want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.Ciphertext !== C1_CT) $display("FAIL c1_ct: got %h want %h", bus.Ciphertext, C1_CT);
    else passed++;
    repeat (5) tick();
    checks++;
    if (bus.Ready !== 1'b1) $display("FAIL c1_ready_hold: got %b want 1", bus.Ready);
    else passed++;
    checks++;
    if (bus.Ciphertext !== C1_CT) $display("FAIL c1_ct_hold: got %h want %h", bus.Ciphertext, C1_CT);
    else passed++;
  endtask

  task automatic test_fips_b();
    int n;
    logic [127:0] exp_k;
    accept_block(B_PT, B_KEY);
    checks++;
    if (bus.Ready !== 1'b0) $display("FAIL b_ready_drop: got %b want 0", bus.Ready);
    else passed++;
    tick();
    expand_key(B_KEY);
    exp_k = (KSTEP == 1) ? B_RK1 : rk_m[KSTEP];
    checks++;
    if (dut.key_q !== exp_k) $display("FAIL b_round_key: got %h want %h", dut.key_q, exp_k);
    else passed++;
    wait_ready(1, n);
    checks++;
    if (n !== LAT) $display("FAIL b_latency: got %0d want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.Ciphertext !== B_CT) $display("FAIL b_ct: got %h want %h", bus.Ciphertext, B_CT);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_r;
    bus.Run       = 1'b1;
    bus.Plaintext = '0;
    bus.Cipherkey = '0;
    tick();
    for (int k = 1; k <= 3 * PERIOD; k++) begin
      tick();
      exp_r = ((k % PERIOD) == LAT);
      checks++;
      if (bus.Ready !== exp_r) $display("FAIL b2b_ready[%0d]: got %b want %b", k, bus.Ready, exp_r);
      else passed++;
      if (exp_r) begin
        checks++;
        if (bus.Ciphertext !== Z_CT) $display("FAIL b2b_ct[%0d]: got %h want %h", k, bus.Ciphertext, Z_CT);
        else passed++;
      end
    end
    bus.Run = 1'b0;
    wait_ready(0, n);
  endtask

  task automatic test_run_ignored();
    int n;
    int pulse_at;
    pulse_at = (LAT == 10) ? 4 : 2;
    accept_block(C1_PT, C1_KEY);
    repeat (pulse_at) tick();
    bus.Run       = 1'b1;
    bus.Plaintext = rand128();
    bus.Cipherkey = rand128();
    tick();
    bus.Run = 1'b0;
    wait_ready(pulse_at + 1, n);
    checks++;
    if (n !== LAT) $display("FAIL ign_latency: got %0d want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.Ciphertext !== C1_CT) $display("FAIL ign_ct: got %h want %h", bus.Ciphertext, C1_CT);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    accept_block(C1_PT, C1_KEY);
    repeat ((LAT == 10) ? 6 : 3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (bus.Ready !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", bus.Ready);
    else passed++;
    checks++;
    if (bus.Ciphertext !== 128'h0) $display("FAIL rstmid_ct: got %h want 0", bus.Ciphertext);
    else passed++;
    checks++;
    if (dut.state_q !== 128'h0) $display("FAIL rstmid_state: got %h want 0", dut.state_q);
    else passed++;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.Ready !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL rstmid_quiet: Ready seen in %0d cycles, want 0", bad);
    else passed++;
    accept_block(C1_PT, C1_KEY);
    wait_ready(0, n);
    checks++;
    if (n !== LAT) $display("FAIL rstmid_latency: got %0d want %0d", n, LAT);
    else passed++;
    checks++;
    if (bus.Ciphertext !== C1_CT) $display("FAIL rstmid_ct2: got %h want %h", bus.Ciphertext, C1_CT);
    else passed++;
  endtask

  task automatic test_run_reset_same();
    int seen;
    bus.Run       = 1'b1;
    bus.Plaintext = C1_PT;
    bus.Cipherkey = C1_KEY;
    Reset         = 1'b1;
    tick();
    Reset   = 1'b0;
    bus.Run = 1'b0;
    seen = 0;
    repeat (LAT + 3) begin
      tick();
      if (bus.Ready !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL runrst_lost: Ready seen in %0d cycles, want 0", seen);
    else passed++;
  endtask

  task automatic test_loopback();
    int n;
    logic [127:0] pt, key, exp_ct, rec;
    for (int v = 0; v < 1000; v++) begin
      pt  = rand128();
      key = rand128();
      accept_block(pt, key);
      checks++;
      if (bus.Ready !== 1'b0) $display("FAIL lb_ready_drop[%0d]: got %b want 0", v, bus.Ready);
      else passed++;
      wait_ready(0, n);
      checks++;
      if (n !== LAT) $display("FAIL lb_latency[%0d]: got %0d want %0d", v, n, LAT);
      else passed++;
      exp_ct = model_enc(pt, key);
      checks++;
      if (bus.Ciphertext !== exp_ct) $display("FAIL lb_ct[%0d]: got %h want %h", v, bus.Ciphertext, exp_ct);
      else passed++;
      rec = model_dec(bus.Ciphertext, key);
      checks++;
      if (rec !== pt) $display("FAIL lb_plain[%0d]: got %h want %h", v, rec, pt);
      else passed++;
    end
  endtask

  initial begin
    bus.Run       = 1'b0;
    bus.Plaintext = '0;
    bus.Cipherkey = '0;
    init_model();
    tick();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_run_ignored();
    test_reset_mid();
    test_run_reset_same();
    test_loopback();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
